// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register and write-back stage: latches the ALU result, commits it once into the register file.
// Optional macro WB_BYPASS_EN forwards the value being committed onto the rs read port in the same cycle.
module ex_wb_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_N  = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned ADDR_W = (REG_N > 1) ? $clog2(REG_N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_ans,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [CNT_W-1:0]  retire_count
);

  logic              valid_q, valid_d;
  logic              done_q,  done_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;
  logic              rw_q,    rw_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];

  logic commit;
  logic we;

  // An entry commits only in its first WB cycle; done_q remembers it across stalls.
  assign commit = valid_q & ~done_q;
  assign we     = commit & rw_q;

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    data_d   = data_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    retire_d = retire_q;
    regs_d   = regs_q;

    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall) begin
      done_d = done_q | commit;
    end else begin
      valid_d = ex_valid;
      data_d  = ex_ans;
      rd_d    = ex_rd;
      rw_d    = ex_reg_write;
      done_d  = 1'b0;
    end

    // The resident entry writes even when the stage is being flushed or stalled.
    if (we) begin
      regs_d[rd_q] = data_q;
    end

    if (commit) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      retire_q <= '0;
      regs_q   <= '{default: '0};
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      retire_q <= retire_d;
      regs_q   <= regs_d;
    end
  end

  assign wb_data      = data_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = valid_q & rw_q;
  assign retire_count = retire_q;

  // Combinational read port feeding the ALU operand.
  always_comb begin
    rs_data = regs_q[rs_addr];
`ifdef WB_BYPASS_EN
    if (we && (rs_addr == rd_q)) begin
      rs_data = data_q;
    end
`endif
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: scoreboard of expected write-back bus entries plus per-scenario checks.
module tb_ex_wb_stage;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned CNT_W  = 16;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] rd;
    logic       wr;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_ans;
  logic [2:0]        ex_rd;
  logic              ex_reg_write;
  logic              stall;
  logic              flush;
  logic [2:0]        rs_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        wb_rd;
  logic              wb_reg_write;
  logic [CNT_W-1:0]  retire_count;

  wb_exp_t          exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_retire = '0;

  ex_wb_stage #(.DATA_W(DATA_W), .REG_N(REG_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ans(ex_ans), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .stall(stall), .flush(flush), .rs_addr(rs_addr),
    .rs_data(rs_data), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_ans = '0; ex_rd = '0; ex_reg_write = 1'b0;
    stall = 1'b0; flush = 1'b0;
  endtask

  // Drive one EX instruction; an unflushed load is expected on the wb bus after the next edge.
  task automatic issue(input logic [7:0] a, input logic [2:0] r, input logic w);
    ex_valid = 1'b1; ex_ans = a; ex_rd = r; ex_reg_write = w;
    if (!flush) exp_q.push_back('{data: a, rd: r, wr: w});
  endtask

  task automatic pop_exp(output wb_exp_t e);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: no expected wb entry queued");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    wb_exp_t dummy;
    dummy = '0;
    reset = 1'b1; idle_inputs(); rs_addr = '0;
    #3;
    checks++;
    if ({wb_data, wb_rd, wb_reg_write} !== {dummy.data, dummy.rd, dummy.wr} || retire_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: wb_data=%h wb_rd=%0d wb_we=%b retire=%h, required all 0",
               wb_data, wb_rd, wb_reg_write, retire_count);
    end
    for (int i = 0; i < 8; i++) begin
      rs_addr = 3'(i); #1;
      checks++;
      if (rs_data !== 8'h00) begin
        errors++; $display("FAIL reset_reg%0d: got %h, required 00", i, rs_data);
      end
    end
    @(negedge clk); reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    wb_exp_t e;
    issue(8'h3C, 3'd5, 1'b1); rs_addr = 3'd5;
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL basic_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    checks++;
    if (rs_data !== (BYP ? 8'h3C : 8'h00)) begin
      errors++; $display("FAIL basic_same_cycle_read: got %h, required %h", rs_data, BYP ? 8'h3C : 8'h00);
    end
    step();
    exp_retire++;
    checks++;
    if (rs_data !== 8'h3C || retire_count !== exp_retire || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL basic_commit: rs=%h retire=%h we=%b, required 3c/%h/0",
                         rs_data, retire_count, wb_reg_write, exp_retire);
    end
  endtask

  task automatic test_stall();
    wb_exp_t e;
    issue(8'hA5, 3'd2, 1'b1); rs_addr = 3'd2;
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL stall_load_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) exp_retire++;
      checks++;
      if (wb_reg_write !== 1'b1 || wb_data !== 8'hA5 || rs_data !== 8'hA5 || retire_count !== exp_retire) begin
        errors++; $display("FAIL stall_cycle%0d: we=%b data=%h rs=%h retire=%h, required 1/a5/a5/%h",
                           i, wb_reg_write, wb_data, rs_data, retire_count, exp_retire);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (wb_reg_write !== 1'b0 || retire_count !== exp_retire) begin
      errors++; $display("FAIL stall_release: we=%b retire=%h, required 0/%h",
                         wb_reg_write, retire_count, exp_retire);
    end
  endtask

  task automatic test_flush();
    wb_exp_t e;
    flush = 1'b1; issue(8'h11, 3'd3, 1'b1);
    step(); idle_inputs();
    checks++;
    if (wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: we=%b, required 0", wb_reg_write);
    end
    step(); rs_addr = 3'd3; #1;
    checks++;
    if (rs_data !== 8'h00 || retire_count !== exp_retire) begin
      errors++; $display("FAIL flush_no_commit: r3=%h retire=%h, required 00/%h", rs_data, retire_count, exp_retire);
    end
    // Resident entry still commits on the edge where flush and stall are both high.
    issue(8'h22, 3'd6, 1'b1);
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL flush_load_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    stall = 1'b1; flush = 1'b1;
    step(); exp_retire++;
    rs_addr = 3'd6; #1;
    checks++;
    if (wb_reg_write !== 1'b0 || rs_data !== 8'h22 || retire_count !== exp_retire) begin
      errors++; $display("FAIL flush_stall_commit: we=%b r6=%h retire=%h, required 0/22/%h",
                         wb_reg_write, rs_data, retire_count, exp_retire);
    end
    issue(8'h33, 3'd7, 1'b1);
    step(); idle_inputs();
    checks++;
    if (wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_stall_bubble: we=%b, required 0", wb_reg_write);
    end
    step(); rs_addr = 3'd7; #1;
    checks++;
    if (rs_data !== 8'h00 || retire_count !== exp_retire) begin
      errors++; $display("FAIL flush_stall_no_commit: r7=%h retire=%h, required 00/%h",
                         rs_data, retire_count, exp_retire);
    end
  endtask

  task automatic test_no_write();
    wb_exp_t e;
    issue(8'hFF, 3'd1, 1'b0);
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL nowrite_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    step(); exp_retire++;
    rs_addr = 3'd1; #1;
    checks++;
    if (rs_data !== 8'h00 || retire_count !== exp_retire) begin
      errors++; $display("FAIL nowrite_commit: r1=%h retire=%h, required 00/%h", rs_data, retire_count, exp_retire);
    end
  endtask

  task automatic test_back_to_back();
    wb_exp_t    e;
    logic [7:0] d [3] = '{8'h81, 8'h42, 8'hC3};
    logic [2:0] r [3] = '{3'd0, 3'd1, 3'd0};
    for (int i = 0; i < 3; i++) begin
      issue(d[i], r[i], 1'b1);
      step();
      pop_exp(e);
      checks++;
      if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
        errors++; $display("FAIL b2b_wb%0d: got %h/%0d/%b, required %h/%0d/%b",
                           i, wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
      end
    end
    idle_inputs(); rs_addr = 3'd0; #1;
    checks++;
    if (rs_data !== (BYP ? 8'hC3 : 8'h81)) begin
      errors++; $display("FAIL b2b_r0_pending: got %h, required %h", rs_data, BYP ? 8'hC3 : 8'h81);
    end
    step(); exp_retire += 3;
    checks++;
    if (rs_data !== 8'hC3 || retire_count !== exp_retire) begin
      errors++; $display("FAIL b2b_r0_final: r0=%h retire=%h, required c3/%h", rs_data, retire_count, exp_retire);
    end
    rs_addr = 3'd1; #1;
    checks++;
    if (rs_data !== 8'h42) begin
      errors++; $display("FAIL b2b_r1: got %h, required 42", rs_data);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 65535 - int'(exp_retire);
    ex_valid = 1'b1; ex_reg_write = 1'b0; ex_ans = 8'h00; ex_rd = 3'd0;
    for (int i = 0; i < n; i++) step();
    idle_inputs();
    step();
    checks++;
    if (retire_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preset: retire=%h, required ffff", retire_count);
    end
    ex_valid = 1'b1;
    step(); idle_inputs();
    step(); exp_retire = '0;
    checks++;
    if (retire_count !== exp_retire) begin
      errors++; $display("FAIL wrap_to_zero: retire=%h, required 0000", retire_count);
    end
  endtask

  task automatic test_bypass();
    wb_exp_t e;
    issue(8'h7E, 3'd4, 1'b1); rs_addr = 3'd4;
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL bypass_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    checks++;
    if (rs_data !== (BYP ? 8'h7E : 8'h00)) begin
      errors++; $display("FAIL bypass_same_cycle: got %h, required %h", rs_data, BYP ? 8'h7E : 8'h00);
    end
    step(); exp_retire++;
    checks++;
    if (rs_data !== 8'h7E || retire_count !== exp_retire) begin
      errors++; $display("FAIL bypass_commit: r4=%h retire=%h, required 7e/%h", rs_data, retire_count, exp_retire);
    end
  endtask

  task automatic test_reset_mid_commit();
    wb_exp_t e;
    issue(8'h5A, 3'd3, 1'b1); rs_addr = 3'd3;
    step(); idle_inputs();
    pop_exp(e);
    checks++;
    if (wb_data !== e.data || wb_rd !== e.rd || wb_reg_write !== e.wr) begin
      errors++; $display("FAIL rstmid_wb: got %h/%0d/%b, required %h/%0d/%b",
                         wb_data, wb_rd, wb_reg_write, e.data, e.rd, e.wr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (wb_data !== 8'h00 || wb_rd !== 3'd0 || wb_reg_write !== 1'b0 || retire_count !== 16'h0 || rs_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: data=%h rd=%0d we=%b retire=%h rs=%h, required all 0",
                         wb_data, wb_rd, wb_reg_write, retire_count, rs_data);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rs_addr = 3'(i); #1;
      checks++;
      if (rs_data !== 8'h00) begin
        errors++; $display("FAIL rstmid_reg%0d: got %h, required 00", i, rs_data);
      end
    end
    @(negedge clk); reset = 1'b0;
    rs_addr = 3'd3;
    step();
    checks++;
    if (rs_data !== 8'h00 || retire_count !== 16'h0 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: r3=%h retire=%h we=%b, required 00/0000/0",
                         rs_data, retire_count, wb_reg_write);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_no_write();
    test_back_to_back();
    test_wrap();
    test_bypass();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
